// File: rtl/piso_pkg.sv
// Shared definitions for the PISO frame serializer: state encoding and default word width.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Saturating bit counter: counts 0..WIDTH-1, holds at the top, and flags the terminal count.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(WIDTH - 1));

  // Clear wins over enable so a back-to-back load restarts the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer feeding siso_shift_reg, with gapless back-to-back frames.
// Optional trailing even-parity bit when PISO_FRAME_SERIALIZER_PARITY_EN is defined.
module piso_frame_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tc, accept, last;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept || (state_q != ST_SHIFT)),
    .en_i  (state_q == ST_SHIFT),
    .tc_o  (tc)
  );

`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst)         par_q <= 1'b0;
    else if (accept) par_q <= ^din;
  end
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last       = 1'b0;
    sout       = IDLE_LEVEL;
    sout_valid = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        sout_valid = 1'b1;
        sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        shreg_d    = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
        if (tc) state_d = ST_PARITY;
`else
        last = tc;
        if (tc) state_d = ST_IDLE;
`endif
      end
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
      ST_PARITY: begin
        sout_valid = 1'b1;
        sout       = par_q;
        last       = 1'b1;
        state_d    = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Ready in idle and on the final output cycle, so the next word follows with no gap.
    din_ready = !rst && ((state_q == ST_IDLE) || last);
    accept    = din_valid && din_ready;
    if (accept) begin
      state_d = ST_SHIFT;
      shreg_d = din;
    end
  end

  assign done = last;
  assign busy = sout_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: MSB-first and LSB-first instances sharing clock and reset.
module tb_piso_frame_serializer;

  localparam int W = 8;
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_m = '0, din_l = '0;
  logic       dv_m = 1'b0, dv_l = 1'b0;
  logic       rdy_m, sout_m, sv_m, busy_m, done_m;
  logic       rdy_l, sout_l, sv_l, busy_l, done_l;
  logic [3:0] exp_v, obs_v;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_frame_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  // Expected serial bit on frame cycle i (1-based); cycles past W carry even parity.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    logic [7:0] t;
    t = w;
    if (i > W) return ^t;
    return msb ? t[W-i] : t[i-1];
  endfunction

  task automatic test_reset();
    #7;
    obs_v = {sout_m, sv_m, busy_m, done_m};
    checks++;
    if (obs_v !== 4'b0000) begin errors++; $display("FAIL reset_outs_m got %b exp 0000", obs_v); end
    obs_v = {sout_l, sv_l, busy_l, done_l};
    checks++;
    if (obs_v !== 4'b0000) begin errors++; $display("FAIL reset_outs_l got %b exp 0000", obs_v); end
    checks++;
    if ({rdy_m, rdy_l} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {rdy_m, rdy_l}); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({rdy_m, rdy_l} !== 2'b11) begin errors++; $display("FAIL idle_ready got %b exp 11", {rdy_m, rdy_l}); end
  endtask

  task automatic test_msb_first();
    @(posedge clk); #1 din_m = 8'hA5; dv_m = 1'b1;
    for (int i = 1; i <= FL + 1; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin dv_m = 1'b0; din_m = 8'h00; end
      @(negedge clk);
      exp_v = (i <= FL) ? {exp_bit(8'hA5, i, 1'b1), 2'b11, (i == FL)} : 4'b0000;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL msb_first cyc %0d got %b exp %b", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_lsb_first();
    @(posedge clk); #1 din_l = 8'h0F; dv_l = 1'b1;
    for (int i = 1; i <= FL + 1; i++) begin
      @(posedge clk); #1;
      if (i == 1) dv_l = 1'b0;
      @(negedge clk);
      exp_v = (i <= FL) ? {exp_bit(8'h0F, i, 1'b0), 2'b11, (i == FL)} : 4'b0000;
      obs_v = {sout_l, sv_l, busy_l, done_l};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL lsb_first cyc %0d got %b exp %b", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 din_m = 8'hF0; dv_m = 1'b1;
    for (int i = 1; i <= 2 * FL + 1; i++) begin
      @(posedge clk); #1;
      if (i == 1) din_m = 8'h3C;
      if (i == FL + 1) dv_m = 1'b0;
      @(negedge clk);
      if (i <= FL)          exp_v = {exp_bit(8'hF0, i, 1'b1), 2'b11, (i == FL)};
      else if (i <= 2 * FL) exp_v = {exp_bit(8'h3C, i - FL, 1'b1), 2'b11, (i == 2 * FL)};
      else                  exp_v = 4'b0000;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL b2b cyc %0d got %b exp %b", i, obs_v, exp_v); end
      if (i == 4 || i == FL) begin
        checks++;
        if (rdy_m !== (i == FL)) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", i, rdy_m, (i == FL)); end
      end
    end
  endtask

  task automatic test_ignore_valid();
    @(posedge clk); #1 din_m = 8'hA5; dv_m = 1'b1;
    for (int i = 1; i <= FL + 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) dv_m = 1'b0;
      if (i == 4) begin din_m = 8'hFF; dv_m = 1'b1; end
      if (i == 5) dv_m = 1'b0;
      @(negedge clk);
      exp_v = (i <= FL) ? {exp_bit(8'hA5, i, 1'b1), 2'b11, (i == FL)} : 4'b0000;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL ignore cyc %0d got %b exp %b", i, obs_v, exp_v); end
      if (i == 4) begin
        checks++;
        if (rdy_m !== 1'b0) begin errors++; $display("FAIL ignore_ready got %b exp 0", rdy_m); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1 din_m = 8'hA5; dv_m = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) dv_m = 1'b0;
      if (i == 4) rst = 1'b1;
      if (i == 5) rst = 1'b0;
      @(negedge clk);
      exp_v = (i <= 4) ? {exp_bit(8'hA5, i, 1'b1), 2'b11, 1'b0} : 4'b0000;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL rst_mid cyc %0d got %b exp %b", i, obs_v, exp_v); end
      if (i == 4) begin
        checks++;
        if (rdy_m !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b exp 0", rdy_m); end
      end
    end
    // A fresh frame after the abort must serialize from its first bit.
    #1 din_m = 8'h3C; dv_m = 1'b1;
    for (int i = 1; i <= FL + 1; i++) begin
      @(posedge clk); #1;
      if (i == 1) dv_m = 1'b0;
      @(negedge clk);
      exp_v = (i <= FL) ? {exp_bit(8'h3C, i, 1'b1), 2'b11, (i == FL)} : 4'b0000;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL rst_recover cyc %0d got %b exp %b", i, obs_v, exp_v); end
    end
  endtask

`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
  task automatic test_parity();
    @(posedge clk); #1 din_m = 8'h07; dv_m = 1'b1;
    for (int i = 1; i <= FL + 1; i++) begin
      @(posedge clk); #1;
      if (i == 1) dv_m = 1'b0;
      @(negedge clk);
      exp_v = (i <= FL) ? {exp_bit(8'h07, i, 1'b1), 2'b11, (i == FL)} : 4'b0000;
      if (i == W + 1) exp_v = 4'b1111;
      obs_v = {sout_m, sv_m, busy_m, done_m};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL parity cyc %0d got %b exp %b", i, obs_v, exp_v); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid_frame();
`ifdef PISO_FRAME_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
